// File: rtl/iter_divider_if.sv
// Operand/result bundle for iter_divider. Signal names follow the vendor divider
// cores so the multiply/divide bridge can be rewired without renaming.
interface iter_divider_if #(
  parameter int WIDTH = 32
);
  logic                 s_axis_divisor_tvalid;
  logic [WIDTH-1:0]     s_axis_divisor_tdata;
  logic                 s_axis_dividend_tvalid;
  logic [WIDTH-1:0]     s_axis_dividend_tdata;
  logic                 s_signed;
  logic                 busy;
  logic                 m_axis_dout_tvalid;
  logic [2*WIDTH-1:0]   m_axis_dout_tdata;

  modport master (
    output s_axis_divisor_tvalid, s_axis_divisor_tdata,
    output s_axis_dividend_tvalid, s_axis_dividend_tdata,
    output s_signed,
    input  busy, m_axis_dout_tvalid, m_axis_dout_tdata
  );

  modport slave (
    input  s_axis_divisor_tvalid, s_axis_divisor_tdata,
    input  s_axis_dividend_tvalid, s_axis_dividend_tdata,
    input  s_signed,
    output busy, m_axis_dout_tvalid, m_axis_dout_tdata
  );
endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring divider, signed or unsigned, fixed latency WIDTH+2 cycles.
// Result packing: {quotient, remainder}; divide-by-zero returns {all ones, raw dividend}.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic          aclk,
  input  logic          aresetn,
  iter_divider_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 signed_q, signed_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     div_q, div_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 bzero_q, bzero_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 tvalid_q, tvalid_d;
  logic [2*WIDTH-1:0]   tdata_q, tdata_d;

  logic                 accept;
  logic [WIDTH:0]       shift_rem;
  logic                 trial_ok;
  logic [WIDTH-1:0]     step_rem;
  logic [WIDTH-1:0]     step_quo;
  logic [WIDTH-1:0]     fin_quo;
  logic [WIDTH-1:0]     fin_rem;
  logic [2*WIDTH-1:0]   result;

  assign accept = bus.s_axis_divisor_tvalid & bus.s_axis_dividend_tvalid;

  // One restoring step. The shifted remainder needs WIDTH+1 bits because |B|
  // may be as large as 2^WIDTH-1; after a successful subtract it fits WIDTH bits again.
  always_comb begin
    shift_rem = {rem_q, quo_q[WIDTH-1]};
    trial_ok  = (shift_rem >= {1'b0, div_q});
    step_rem  = trial_ok ? (shift_rem[WIDTH-1:0] - div_q) : shift_rem[WIDTH-1:0];
    step_quo  = {quo_q[WIDTH-2:0], trial_ok};
    fin_quo   = qneg_q ? -step_quo : step_quo;
    fin_rem   = rneg_q ? -step_rem : step_rem;
    result    = bzero_q ? {{WIDTH{1'b1}}, a_q} : {fin_quo, fin_rem};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    div_d    = div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    bzero_d  = bzero_q;
    count_d  = count_q;
    tvalid_d = 1'b0;
    tdata_d  = tdata_q;

    unique case (state_q)
      // The result cycle also accepts, which gives back-to-back operation
      // with a fixed WIDTH+2 cycle spacing between results.
      S_IDLE, S_FIX: begin
        if (accept) begin
          a_d      = bus.s_axis_dividend_tdata;
          b_d      = bus.s_axis_divisor_tdata;
          signed_d = bus.s_signed;
          state_d  = S_PREP;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_PREP: begin
        quo_d   = (signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
        div_d   = (signed_q && b_q[WIDTH-1]) ? -b_q : b_q;
        qneg_d  = signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_d  = signed_q & a_q[WIDTH-1];
        bzero_d = (b_q == '0);
        rem_d   = '0;
        count_d = '0;
        state_d = S_ITER;
      end

      S_ITER: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + 1'b1;
        // Last step: sign fix and packing happen on the way into the result cycle.
        if (count_q == CW'(WIDTH - 1)) begin
          tvalid_d = 1'b1;
          tdata_d  = result;
          state_d  = S_FIX;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      count_q  <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      bzero_q  <= bzero_d;
      count_q  <= count_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
    end
  end

  assign bus.busy               = (state_q != S_IDLE);
  assign bus.m_axis_dout_tvalid = tvalid_q;
  assign bus.m_axis_dout_tdata  = tdata_q;

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: table of known quotient/remainder pairs, timing and
// reset sequences, then random operands against a plain-arithmetic reference.
module tb_iter_divider;

  localparam int LAT = 34;

  logic aclk;
  logic aresetn;
  int   n_vec;
  int   n_err;
  int   n_cmp;

  iter_divider_if #(.WIDTH(32)) bus ();

  iter_divider #(.WIDTH(32)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    string       name;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    int          sa;
    int          sb;
    int          sq;
    int          sr;
    logic [31:0] uq;
    logic [31:0] ur;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sq, sr};
    end
    uq = a / b;
    ur = a % b;
    return {uq, ur};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive_ops(input logic v, input logic [31:0] a, input logic [31:0] b, input logic sgn);
    bus.s_axis_dividend_tvalid = v;
    bus.s_axis_divisor_tvalid  = v;
    bus.s_axis_dividend_tdata  = a;
    bus.s_axis_divisor_tdata   = b;
    bus.s_signed               = sgn;
  endtask

  // One divide from an idle DUT: latency, result, busy over cycles 1..LAT.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] exp, input string name);
    int          lat;
    int          busy_low;
    logic [63:0] got;
    lat      = -1;
    busy_low = 0;
    got      = '0;
    @(negedge aclk);
    drive_ops(1'b1, a, b, sgn);
    @(posedge aclk);
    #1 drive_ops(1'b0, 32'd0, 32'd0, 1'b0);
    for (int k = 1; k <= LAT + 20; k++) begin
      @(negedge aclk);
      if (k <= LAT && !bus.busy) busy_low++;
      if (bus.m_axis_dout_tvalid) begin
        lat = k;
        got = bus.m_axis_dout_tdata;
        break;
      end
    end
    n_vec++;
    check({name, " latency"}, 64'(lat), 64'(LAT));
    check({name, " tdata"}, got, exp);
    check({name, " busy"}, 64'(busy_low), 64'd0);
    $display("vec %0d %s: a=%h b=%h signed=%0d -> tdata=%h lat=%0d", n_vec, name, a, b, sgn, got, lat);
  endtask

  // Divide with an optional second operand pulse at cycle inj_k and optional
  // reset at cycle rst_k; records the first two result pulses.
  task automatic seq_run(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int inj_k, input logic [31:0] a2, input logic [31:0] b2, input logic sgn2,
                         input int rst_k, input int ncyc,
                         output int np, output int p1, output int p2,
                         output logic [63:0] d1, output logic [63:0] d2,
                         output logic rst_busy, output logic [63:0] rst_tdata);
    np = 0; p1 = -1; p2 = -1; d1 = '0; d2 = '0; rst_busy = 1'b1; rst_tdata = '1;
    @(negedge aclk);
    drive_ops(1'b1, a, b, sgn);
    @(posedge aclk);
    #1 drive_ops(1'b0, 32'd0, 32'd0, 1'b0);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge aclk);
      if (bus.m_axis_dout_tvalid) begin
        np++;
        if (np == 1) begin p1 = k; d1 = bus.m_axis_dout_tdata; end
        if (np == 2) begin p2 = k; d2 = bus.m_axis_dout_tdata; end
      end
      if (k == rst_k + 1) begin
        rst_busy  = bus.busy;
        rst_tdata = bus.m_axis_dout_tdata;
        aresetn   = 1'b1;
      end
      if (k == rst_k) aresetn = 1'b0;
      if (k == inj_k + 1) drive_ops(1'b0, 32'd0, 32'd0, 1'b0);
      if (k == inj_k) drive_ops(1'b1, a2, b2, sgn2);
    end
    n_vec++;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          np, p1, p2;
    logic [63:0] d1, d2, rt;
    logic        rb;
    logic [31:0] ra, rbv;
    logic        rs;
    int          sel;

    n_vec = 0; n_err = 0; n_cmp = 0;
    tbl[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          "divu_100_7"};
    tbl[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  "div_m7_2"};
    tbl[2]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          "div_7_m2"};
    tbl[3]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          "divu_max_1"};
    tbl[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          "div_ovf"};
    tbl[5]  = '{32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678,  "div_by0"};
    tbl[6]  = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  "divu_by0"};
    tbl[7]  = '{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  "div_neg_by0"};
    tbl[8]  = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          "divu_big_2"};
    tbl[9]  = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  "div_m7_m2"};
    tbl[10] = '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          "divu_small"};
    tbl[11] = '{32'h8000_0000,  32'd1,          1'b1, 32'h8000_0000,  32'd0,          "div_min_1"};
    tbl[12] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  "divu_min_max"};
    tbl[13] = '{32'd0,          32'hFFFF_FFFB,  1'b1, 32'd0,          32'd0,          "div_0_m5"};

    aresetn = 1'b0;
    drive_ops(1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset tvalid", 64'(bus.m_axis_dout_tvalid), 64'd0);
    check("reset tdata", bus.m_axis_dout_tdata, 64'd0);
    aresetn = 1'b1;

    // A lone tvalid on either channel must not start a divide.
    @(negedge aclk);
    bus.s_axis_dividend_tvalid = 1'b1;
    bus.s_axis_dividend_tdata  = 32'd9;
    @(negedge aclk);
    check("dividend only busy", 64'(bus.busy), 64'd0);
    bus.s_axis_dividend_tvalid = 1'b0;
    bus.s_axis_divisor_tvalid  = 1'b1;
    bus.s_axis_divisor_tdata   = 32'd3;
    @(negedge aclk);
    check("divisor only busy", 64'(bus.busy), 64'd0);
    drive_ops(1'b0, 32'd0, 32'd0, 1'b0);
    n_vec++;

    for (int i = 0; i < 14; i++)
      run_div(tbl[i].a, tbl[i].b, tbl[i].sgn, {tbl[i].exp_q, tbl[i].exp_r}, tbl[i].name);

    // Operands offered at cycle 10 are dropped; result pulse lasts one cycle.
    seq_run(32'd100, 32'd7, 1'b0, 10, 32'd50, 32'd5, 1'b0, -5, 80, np, p1, p2, d1, d2, rb, rt);
    check("ignore pulses", 64'(np), 64'd1);
    check("ignore p1", 64'(p1), 64'(LAT));
    check("ignore d1", d1, {32'd14, 32'd2});
    check("tdata held", bus.m_axis_dout_tdata, {32'd14, 32'd2});
    $display("seq ignore: pulses=%0d at %0d tdata=%h", np, p1, d1);

    // Second accept on the result edge.
    seq_run(32'd100, 32'd7, 1'b0, LAT, 32'hFFFF_FFF9, 32'd2, 1'b1, -5, 80, np, p1, p2, d1, d2, rb, rt);
    check("b2b pulses", 64'(np), 64'd2);
    check("b2b p1", 64'(p1), 64'(LAT));
    check("b2b p2", 64'(p2), 64'(2 * LAT));
    check("b2b d2", d2, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    $display("seq b2b: pulses=%0d at %0d,%0d tdata2=%h", np, p1, p2, d2);

    // Reset mid-divide aborts without a result.
    seq_run(32'd1000, 32'd3, 1'b0, -5, 32'd0, 32'd0, 1'b0, 20, 60, np, p1, p2, d1, d2, rb, rt);
    check("abort pulses", 64'(np), 64'd0);
    check("abort busy", 64'(rb), 64'd0);
    check("abort tdata", rt, 64'd0);
    $display("seq abort: pulses=%0d busy=%0d tdata=%h", np, rb, rt);
    run_div(32'd9, 32'd3, 1'b0, {32'd3, 32'd0}, "after_reset_9_3");

    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 7);
      ra  = $urandom;
      rbv = $urandom;
      rs  = 1'($urandom_range(0, 1));
      case (sel)
        0: rbv = 32'd0;
        1: begin ra = 32'h8000_0000; rbv = 32'hFFFF_FFFF; end
        2: rbv = 32'($urandom_range(1, 20));
        3: rbv = ra + 32'($urandom_range(0, 2)) - 32'd1;
        default: ;
      endcase
      run_div(ra, rbv, rs, ref_div(ra, rbv, rs), "random");
    end

    $display("checks made: %0d", n_cmp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
